// File: rtl/alu_pkg.sv
// Shared ALU constants: sequential adder FSM encoding and op codes.
// Imported by the multi-cycle adder datapath.
package alu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_seq_nbit_if.sv
// Operand/result handshake bundle for the sequential adder.
// master = producer/consumer side, slave = adder side.
interface adder_seq_nbit_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/adder_chunk.sv
// CHUNK-bit combinational ripple slice; also exposes the carry
// into its MSB so the caller can derive signed overflow.
module adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             c_msb_o
);

  logic [CHUNK:0] c;

  always_comb begin
    c     = '0;
    sum_o = '0;
    c[0]  = cin_i;
    for (int i = 0; i < CHUNK; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) |
                 (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o  = c[CHUNK];
  assign c_msb_o = c[CHUNK-1];

endmodule

// File: rtl/adder_seq_nbit.sv
// Multi-cycle add/sub: one CHUNK-bit segment per cycle, LSB first.
// Define ADDER_SAT_EN to clamp overflowing results to signed extremes.
module adder_seq_nbit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  adder_seq_nbit_if.slave bus
);

  localparam int NSEG = WIDTH / CHUNK;
  localparam int SEGW = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [SEGW-1:0] SEG_LAST = SEGW'(NSEG - 1);

`ifdef ADDER_SAT_EN
  localparam logic [WIDTH-1:0] SAT_POS =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};
`endif

  logic [1:0]       state_q, state_d;
  logic [SEGW-1:0]  seg_q, seg_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_seg, b_seg, s_seg;
  logic             c_seg, cm_seg;

  assign a_seg = a_q[seg_q*CHUNK +: CHUNK];
  assign b_seg = b_q[seg_q*CHUNK +: CHUNK];

  adder_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a_i    (a_seg),
    .b_i    (b_seg),
    .cin_i  (carry_q),
    .sum_o  (s_seg),
    .cout_o (c_seg),
    .c_msb_o(cm_seg)
  );

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (1'b1)
      state_q == ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
          carry_d = (bus.sub == OP_SUB);
          seg_d   = '0;
          state_d = ST_BUSY;
        end
      end
      state_q == ST_BUSY: begin
        sum_d[seg_q*CHUNK +: CHUNK] = s_seg;
        carry_d = c_seg;
        seg_d   = seg_q + 1'b1;
        if (seg_q == SEG_LAST) begin
          cout_d  = c_seg;
          ovf_d   = cm_seg ^ c_seg;
          state_d = ST_DONE;
`ifdef ADDER_SAT_EN
          // carry out set on overflow means both inputs were negative
          if (cm_seg ^ c_seg)
            sum_d = c_seg ? SAT_NEG : SAT_POS;
`endif
        end
      end
      state_q == ST_DONE: begin
        if (bus.out_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      seg_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_adder_seq_nbit.sv
// Bench for adder_seq_nbit at 32/8, 16/4 and 8/8 geometries,
// checked against an integer-arithmetic reference model.
module tb_adder_seq_nbit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  adder_seq_nbit_if #(.WIDTH(32)) if32 ();
  adder_seq_nbit_if #(.WIDTH(16)) if16 ();
  adder_seq_nbit_if #(.WIDTH(8))  if8 ();

  adder_seq_nbit #(.WIDTH(32), .CHUNK(8)) u32 (
    .clk(clk), .rst_n(rst_n), .bus(if32)
  );
  adder_seq_nbit #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk(clk), .rst_n(rst_n), .bus(if16)
  );
  adder_seq_nbit #(.WIDTH(8), .CHUNK(8)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(if8)
  );

  int wid[3]  = '{32, 16, 8};
  int nseg[3] = '{4, 4, 1};

  // returns {ovf, cout, sum} from plain integer arithmetic
  function automatic logic [33:0] model(
    int wd, logic [31:0] a, logic [31:0] b, logic s
  );
    longint unsigned m, aa, bb, full, sm;
    logic co, ov, sa, sb, ss;
    m    = (64'd1 << wd) - 1;
    aa   = {32'd0, a} & m;
    bb   = (s ? {32'd0, ~b} : {32'd0, b}) & m;
    full = aa + bb + {63'd0, s};
    sm   = full & m;
    co   = full[wd];
    sa   = aa[wd-1];
    sb   = bb[wd-1];
    ss   = sm[wd-1];
    ov   = (sa == sb) && (ss != sa);
`ifdef ADDER_SAT_EN
    if (ov) sm = sa ? (64'd1 << (wd-1)) : (m >> 1);
`endif
    return {ov, co, sm[31:0]};
  endfunction

  task automatic drive(
    int w, logic v, logic [31:0] a, logic [31:0] b,
    logic s, logic r
  );
    case (w)
      0: begin
        if32.in_valid = v; if32.a = a; if32.b = b;
        if32.sub = s; if32.out_ready = r;
      end
      1: begin
        if16.in_valid = v; if16.a = a[15:0];
        if16.b = b[15:0]; if16.sub = s;
        if16.out_ready = r;
      end
      default: begin
        if8.in_valid = v; if8.a = a[7:0];
        if8.b = b[7:0]; if8.sub = s;
        if8.out_ready = r;
      end
    endcase
  endtask

  task automatic sample(
    int w, output logic rdy, output logic vld,
    output logic [31:0] sm, output logic co,
    output logic ov
  );
    case (w)
      0: begin
        rdy = if32.in_ready; vld = if32.out_valid;
        sm = if32.sum; co = if32.cout; ov = if32.ovf;
      end
      1: begin
        rdy = if16.in_ready; vld = if16.out_valid;
        sm = {16'd0, if16.sum}; co = if16.cout;
        ov = if16.ovf;
      end
      default: begin
        rdy = if8.in_ready; vld = if8.out_valid;
        sm = {24'd0, if8.sum}; co = if8.cout;
        ov = if8.ovf;
      end
    endcase
  endtask

  // full transaction; ok=0 on timeout or unstable held output
  task automatic run_op(
    int w, logic [31:0] a, logic [31:0] b, logic s,
    bit rnd, output logic [31:0] sm, output logic co,
    output logic ov, output int lat, output bit ok
  );
    logic rdy, vld, r, co2, ov2;
    logic [31:0] sm2;
    int n;
    ok = 1; n = 0; lat = 0;
    sample(w, rdy, vld, sm, co, ov);
    while (!rdy && n < 50) begin
      @(posedge clk); #1; n++;
      sample(w, rdy, vld, sm, co, ov);
    end
    if (!rdy) begin ok = 0; return; end
    drive(w, 1'b1, a, b, s, 1'b0);
    @(posedge clk); #1;
    drive(w, 1'b0, a, b, s, 1'b0);
    sample(w, rdy, vld, sm, co, ov);
    while (!vld && lat < 50) begin
      @(posedge clk); #1; lat++;
      sample(w, rdy, vld, sm, co, ov);
    end
    if (!vld) begin ok = 0; return; end
    n = 0;
    do begin
      r = rnd ? logic'($urandom_range(0, 1)) : 1'b1;
      if (n > 20) r = 1'b1;
      drive(w, 1'b0, a, b, s, r);
      sample(w, rdy, vld, sm2, co2, ov2);
      if (!vld || rdy || sm2 !== sm ||
          co2 !== co || ov2 !== ov) ok = 0;
      @(posedge clk); #1; n++;
    end while (!r);
    drive(w, 1'b0, a, b, s, 1'b0);
  endtask

  function automatic logic [31:0] pick(int wd);
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return (32'd1 << (wd - 1)) - 32'd1;
      3: return 32'd1 << (wd - 1);
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    logic rdy, vld, co, ov;
    logic [31:0] sm;
    for (int w = 0; w < 3; w++)
      drive(w, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      sample(w, rdy, vld, sm, co, ov);
      n_cmp++;
      if ({rdy, vld, sm, co, ov} !==
          {1'b1, 1'b0, 32'd0, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL reset[%0d]: got rdy=%b vld=%b sum=%h co=%b ov=%b exp 1 0 0 0 0",
                 w, rdy, vld, sm, co, ov);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] ta[4] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF,
                           32'd5, 32'h8000_0000};
    logic [31:0] tbv[4] = '{32'd1, 32'd1, 32'd7, 32'd1};
    logic ts[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
`ifdef ADDER_SAT_EN
    logic [31:0] es[4] = '{32'h0, 32'h7FFF_FFFF,
                           32'hFFFF_FFFE, 32'h8000_0000};
`else
    logic [31:0] es[4] = '{32'h0, 32'h8000_0000,
                           32'hFFFF_FFFE, 32'h7FFF_FFFF};
`endif
    logic eco[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic eov[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] sm;
    logic co, ov;
    int lat;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      run_op(0, ta[i], tbv[i], ts[i], 1'b0,
             sm, co, ov, lat, ok);
      n_cmp++;
      if (!ok || sm !== es[i]) begin
        n_err++;
        $display("FAIL dir%0d sum: got %h exp %h ok=%0d",
                 i, sm, es[i], ok);
      end
      n_cmp++;
      if (co !== eco[i] || ov !== eov[i]) begin
        n_err++;
        $display("FAIL dir%0d flags: got co=%b ov=%b exp co=%b ov=%b",
                 i, co, ov, eco[i], eov[i]);
      end
      n_cmp++;
      if (lat != 4) begin
        n_err++;
        $display("FAIL dir%0d latency: got %0d exp 4",
                 i, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic rdy, vld, co, ov;
    logic [31:0] sm, a, b;
    logic [33:0] exp;
    int n;
    a = $urandom; b = $urandom;
    exp = model(32, a, b, 1'b0);
    drive(0, 1'b1, a, b, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, a, b, 1'b0, 1'b0);
    n = 0;
    sample(0, rdy, vld, sm, co, ov);
    while (!vld && n < 20) begin
      @(posedge clk); #1; n++;
      sample(0, rdy, vld, sm, co, ov);
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'b1, $urandom, $urandom, 1'b1, 1'b0);
      @(posedge clk); #1;
      sample(0, rdy, vld, sm, co, ov);
      n_cmp++;
      if (!vld || rdy || {ov, co, sm} !== exp) begin
        n_err++;
        $display("FAIL hold%0d: got vld=%b rdy=%b r=%h exp vld=1 rdy=0 r=%h",
                 i, vld, rdy, {ov, co, sm}, exp);
      end
    end
    drive(0, 1'b0, a, b, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, a, b, 1'b0, 1'b0);
    @(posedge clk); #1;
    sample(0, rdy, vld, sm, co, ov);
    n_cmp++;
    if (vld || !rdy) begin
      n_err++;
      $display("FAIL no_queue: got vld=%b rdy=%b exp vld=0 rdy=1",
               vld, rdy);
    end
  endtask

  task automatic test_reset_midop();
    logic rdy, vld, co, ov;
    logic [31:0] sm;
    int lat;
    bit ok;
    drive(0, 1'b1, 32'h1234_5678, 32'h0F0F_0F0F,
          1'b0, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    sample(0, rdy, vld, sm, co, ov);
    n_cmp++;
    if (vld || !rdy || sm !== 32'd0) begin
      n_err++;
      $display("FAIL midop_rst: got vld=%b rdy=%b sum=%h exp 0 1 0",
               vld, rdy, sm);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(0, 32'd3, 32'd4, 1'b0, 1'b0,
           sm, co, ov, lat, ok);
    n_cmp++;
    if (!ok || {ov, co, sm} !== {1'b0, 1'b0, 32'd7} ||
        lat != 4) begin
      n_err++;
      $display("FAIL after_rst: got r=%h lat=%0d exp r=%h lat=4",
               {ov, co, sm}, lat, {2'b00, 32'd7});
    end
  endtask

  task automatic test_random(int w, int nops);
    logic [31:0] a, b, sm;
    logic s, co, ov;
    logic [33:0] exp;
    int lat;
    bit ok;
    for (int i = 0; i < nops; i++) begin
      a = pick(wid[w]);
      b = pick(wid[w]);
      s = logic'($urandom_range(0, 1));
      exp = model(wid[w], a, b, s);
      run_op(w, a, b, s, 1'b1, sm, co, ov, lat, ok);
      n_cmp++;
      if (!ok || {ov, co, sm} !== exp ||
          lat != nseg[w]) begin
        n_err++;
        $display("FAIL rand_w%0d: a=%h b=%h s=%b got %h lat=%0d ok=%0d exp %h lat=%0d",
                 wid[w], a, b, s, {ov, co, sm}, lat, ok,
                 exp, nseg[w]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midop();
    test_random(0, 4000);
    test_random(1, 2000);
    test_random(2, 2000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
